// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, one-entry output register and one-entry
// skid buffer, sequenced by a BOOT/FETCH/HOLD/DRAIN state machine.
module fetch_unit #(
  parameter int                 WIDTH    = 32,
  parameter logic [WIDTH-1:0]   RESET_PC = 32'h0000_0000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PCSRC,
  input  logic [WIDTH-1:0] BRANCH_TARGET,
  input  logic             STALL,
  output logic             IMEM_REQ,
  output logic [WIDTH-1:0] IMEM_ADDR,
  input  logic [WIDTH-1:0] IMEM_RDATA,
  input  logic             IMEM_VALID,
  output logic [WIDTH-1:0] INSTRUCTION,
  output logic [WIDTH-1:0] PC_OUT,
  output logic             INSTR_VALID
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] NOP_INSTR = WIDTH'(32'h0000_0013);

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic             r_imemReq;
  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] r_pcOut;
  logic             r_instrValid;
  logic [WIDTH-1:0] r_skidInstr;
  logic [WIDTH-1:0] r_skidPc;
  logic             r_skidValid;

  logic             w_consumed;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_pcNext;

  assign w_consumed = r_instrValid & ~STALL;
  assign w_target   = BRANCH_TARGET & ~WIDTH'(3);
  assign w_pcNext   = r_pc + WIDTH'(4);

  // IMEM_REQ is registered alongside the state so it is high exactly in FETCH.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= BOOT;
      r_pc         <= RESET_PC;
      r_imemReq    <= 1'b0;
      r_instr      <= NOP_INSTR;
      r_pcOut      <= '0;
      r_instrValid <= 1'b0;
      r_skidInstr  <= NOP_INSTR;
      r_skidPc     <= '0;
      r_skidValid  <= 1'b0;
    end else begin
      if (w_consumed) begin
        r_instrValid <= 1'b0;
      end
      case (r_state)
        BOOT: begin
          r_state   <= FETCH;
          r_imemReq <= 1'b1;
        end
        FETCH: begin
          if (PCSRC) begin
            r_pc         <= w_target;
            r_instrValid <= 1'b0;
            r_skidValid  <= 1'b0;
            if (!IMEM_VALID) begin
              r_state   <= DRAIN;
              r_imemReq <= 1'b0;
            end
          end else if (IMEM_VALID) begin
            r_pc <= w_pcNext;
            if (!r_instrValid || w_consumed) begin
              r_instr      <= IMEM_RDATA;
              r_pcOut      <= r_pc;
              r_instrValid <= 1'b1;
            end else begin
              r_skidInstr <= IMEM_RDATA;
              r_skidPc    <= r_pc;
              r_skidValid <= 1'b1;
              r_state     <= HOLD;
              r_imemReq   <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (PCSRC) begin
            r_pc         <= w_target;
            r_instrValid <= 1'b0;
            r_skidValid  <= 1'b0;
            r_state      <= FETCH;
            r_imemReq    <= 1'b1;
          end else if (w_consumed && r_skidValid) begin
            r_instr      <= r_skidInstr;
            r_pcOut      <= r_skidPc;
            r_instrValid <= 1'b1;
            r_skidValid  <= 1'b0;
            r_state      <= FETCH;
            r_imemReq    <= 1'b1;
          end
        end
        DRAIN: begin
          // A redirect coinciding with the stale response still absorbs that
          // response; nothing else is outstanding, so waiting on would deadlock.
          if (PCSRC) begin
            r_pc         <= w_target;
            r_instrValid <= 1'b0;
            if (IMEM_VALID) begin
              r_state   <= FETCH;
              r_imemReq <= 1'b1;
            end
          end else if (IMEM_VALID) begin
            r_state   <= FETCH;
            r_imemReq <= 1'b1;
          end
        end
        default: begin
          r_state   <= BOOT;
          r_imemReq <= 1'b0;
        end
      endcase
    end
  end

  assign IMEM_REQ    = r_imemReq;
  assign IMEM_ADDR   = r_pc;
  assign INSTRUCTION = r_instr;
  assign PC_OUT      = r_pcOut;
  assign INSTR_VALID = r_instrValid;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a variable-latency memory model and an in-order stream
// scoreboard, driven by directed scenarios followed by randomized traffic.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST;
  logic        PCSRC;
  logic [31:0] BRANCH_TARGET;
  logic        STALL;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_RDATA;
  logic        IMEM_VALID;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC_OUT;
  logic        INSTR_VALID;

  fetch_unit #(.WIDTH(32), .RESET_PC(RESET_PC)) dut (
    .CLK(CLK), .RST(RST), .PCSRC(PCSRC), .BRANCH_TARGET(BRANCH_TARGET),
    .STALL(STALL), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_RDATA(IMEM_RDATA), .IMEM_VALID(IMEM_VALID),
    .INSTRUCTION(INSTRUCTION), .PC_OUT(PC_OUT), .INSTR_VALID(INSTR_VALID)
  );

  always #5 CLK = ~CLK;

  int          total = 0;
  int          bad = 0;
  logic [31:0] expPc;
  int          edgesSinceReset;
  int          consumedCount = 0;
  int          memLatency = 0;
  bit          memPending;
  int          memCount;
  logic [31:0] memAddr;
  bit          spurious = 1'b0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic pulseReset();
    #1 RST = 1'b1;
    IMEM_VALID = 1'b1;
    IMEM_RDATA = 32'hBAD0_BAD0;
    #1;
    checkOutput("reset_req", 32'(IMEM_REQ), 32'd0);
    checkOutput("reset_valid", 32'(INSTR_VALID), 32'd0);
    checkOutput("reset_instr", INSTRUCTION, NOP);
    checkOutput("reset_pcout", PC_OUT, 32'd0);
    checkOutput("reset_addr", IMEM_ADDR, RESET_PC);
    #1 RST = 1'b0;
    IMEM_VALID = 1'b0;
    memPending = 1'b0;
    edgesSinceReset = 0;
    expPc = RESET_PC;
  endtask

  // One clock cycle: called just after a falling edge, returns at the next one.
  task automatic applyStimulus(input bit pcsrc, input logic [31:0] target, input bit stall);
    logic        preReq, preValid;
    logic [31:0] preAddr, prePcOut, preInstr;
    bit          memValid, redirect, bootEdge, doSrc;
    memValid = 1'b0;
    if (memPending) begin
      memCount--;
      if (memCount == 0) begin
        memValid   = 1'b1;
        IMEM_RDATA = memWord(memAddr);
        memPending = 1'b0;
      end
    end else if (IMEM_REQ) begin
      if (memLatency == 0) begin
        memValid   = 1'b1;
        IMEM_RDATA = memWord(IMEM_ADDR);
      end else begin
        memPending = 1'b1;
        memCount   = memLatency;
        memAddr    = IMEM_ADDR;
      end
    end
    if (spurious && !IMEM_REQ) begin
      memValid   = 1'b1;
      IMEM_RDATA = 32'hDEAD_BEEF;
    end
    bootEdge = (edgesSinceReset == 0);
    doSrc = pcsrc;
    if (!bootEdge && !IMEM_REQ && memValid) doSrc = 1'b0;
    IMEM_VALID    = memValid;
    PCSRC         = doSrc;
    BRANCH_TARGET = target;
    STALL         = stall;
    preReq   = IMEM_REQ;
    preValid = INSTR_VALID;
    preAddr  = IMEM_ADDR;
    prePcOut = PC_OUT;
    preInstr = INSTRUCTION;
    redirect = doSrc && !bootEdge;
    if (preValid && !stall) begin
      checkOutput("consume_pc", prePcOut, expPc);
      checkOutput("consume_instr", preInstr, memWord(prePcOut));
      expPc = expPc + 32'd4;
      consumedCount++;
    end
    if (redirect) expPc = target & ~32'h3;
    @(posedge CLK);
    #1;
    edgesSinceReset++;
    if (bootEdge) begin
      checkOutput("boot_req_low", 32'(preReq), 32'd0);
      checkOutput("boot_to_fetch", 32'(IMEM_REQ), 32'd1);
      checkOutput("boot_no_valid", 32'(INSTR_VALID), 32'd0);
      checkOutput("boot_addr", IMEM_ADDR, RESET_PC);
    end else if (redirect) begin
      checkOutput("redirect_valid", 32'(INSTR_VALID), 32'd0);
      checkOutput("redirect_addr", IMEM_ADDR, target & ~32'h3);
      if (preReq) checkOutput("redirect_state", 32'(IMEM_REQ), 32'(memValid));
    end else begin
      if (preReq && !memValid) checkOutput("addr_stable", IMEM_ADDR, preAddr);
      if (preReq && memValid) begin
        checkOutput("pc_advance", IMEM_ADDR, preAddr + 32'd4);
        if (!preValid || !stall) begin
          checkOutput("load_valid", 32'(INSTR_VALID), 32'd1);
          checkOutput("load_pc", PC_OUT, preAddr);
        end else begin
          checkOutput("skid_hold_req", 32'(IMEM_REQ), 32'd0);
        end
      end
      if (preValid && stall) begin
        checkOutput("hold_valid", 32'(INSTR_VALID), 32'd1);
        checkOutput("hold_pc", PC_OUT, prePcOut);
        checkOutput("hold_instr", INSTRUCTION, preInstr);
      end
    end
    spurious = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int n;
    RST = 1'b1; PCSRC = 1'b0; STALL = 1'b0; IMEM_VALID = 1'b0;
    BRANCH_TARGET = '0; IMEM_RDATA = '0;
    memPending = 1'b0; edgesSinceReset = 0; expPc = RESET_PC;
    repeat (2) @(negedge CLK);
    pulseReset();

    // Zero-wait streaming; the redirect on the boot edge must be ignored.
    memLatency = 0;
    applyStimulus(1'b1, 32'h0000_0080, 1'b0);
    repeat (9) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("stream_pc", PC_OUT, 32'd32);
    checkOutput("stream_valid", 32'(INSTR_VALID), 32'd1);

    repeat (3) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("stall_in_hold", 32'(IMEM_REQ), 32'd0);
    repeat (6) applyStimulus(1'b0, '0, 1'b0);

    // Redirect while a 3-cycle response is still outstanding.
    memLatency = 3;
    for (int i = 0; i < 20 && !(memPending && memCount == 3); i++) applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b1, 32'h0000_0040, 1'b0);
    checkOutput("drain_req", 32'(IMEM_REQ), 32'd0);
    checkOutput("drain_valid", 32'(INSTR_VALID), 32'd0);
    for (int i = 0; i < 20 && !INSTR_VALID; i++) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("branch_valid", 32'(INSTR_VALID), 32'd1);
    checkOutput("branch_first_pc", PC_OUT, 32'h0000_0040);

    // Redirect in the same cycle as a response.
    memLatency = 0;
    for (int i = 0; i < 20 && !(IMEM_REQ && !memPending); i++) applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b1, 32'h0000_0103, 1'b0);
    checkOutput("same_cycle_addr", IMEM_ADDR, 32'h0000_0100);
    checkOutput("same_cycle_req", 32'(IMEM_REQ), 32'd1);
    applyStimulus(1'b1, 32'hFFFF_FFFE, 1'b0);
    checkOutput("wrap_start", IMEM_ADDR, 32'hFFFF_FFFC);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("wrap_addr", IMEM_ADDR, 32'h0000_0000);
    repeat (4) applyStimulus(1'b0, '0, 1'b0);

    // Asynchronous reset while holding a skid entry.
    for (int i = 0; i < 20 && !(INSTR_VALID && !IMEM_REQ); i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("hold_entered", 32'(IMEM_REQ), 32'd0);
    pulseReset();
    spurious = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    repeat (6) applyStimulus(1'b0, '0, 1'b0);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0) memLatency = $urandom_range(0, 3);
      if ($urandom_range(0, 599) == 0) pulseReset();
      applyStimulus($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3) == 0);
    end

    memLatency = 1;
    n = consumedCount;
    repeat (20) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("progress", 32'(consumedCount > n + 5), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the width of instruction, address and PC datapaths.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-003 Port list (name, direction, width, meaning), clock and reset first:
- CLK  in  1  single clock; all state updates on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- PCSRC  in  1  redirect request (taken branch).
- BRANCH_TARGET  in  WIDTH  redirect address.
- STALL  in  1  downstream not accepting.
- IMEM_REQ  out  1  instruction memory request.
- IMEM_ADDR  out  WIDTH  fetch address.
- IMEM_RDATA  in  WIDTH  returned instruction word.
- IMEM_VALID  in  1  IMEM_RDATA valid; may assert in the same cycle as IMEM_REQ or any later cycle.
- INSTRUCTION  out  WIDTH  registered instruction to the decode/control stage.
- PC_OUT  out  WIDTH  address of INSTRUCTION.
- INSTR_VALID  out  1  INSTRUCTION/PC_OUT hold a live instruction.

Function
REQ-004 The block SHALL contain a PC register, a one-entry output register (INSTRUCTION, PC_OUT, INSTR_VALID), a one-entry skid buffer (instruction plus its PC), and an FSM with states BOOT, FETCH, HOLD, DRAIN.
REQ-005 The downstream stage SHALL consume an instruction in any cycle where INSTR_VALID=1 and STALL=0; the output register SHALL hold its contents while INSTR_VALID=1 and STALL=1.
REQ-006 IMEM_ADDR SHALL equal the PC register at all times, and the PC SHALL stay stable from IMEM_REQ assertion until IMEM_VALID or a redirect.
REQ-007 In BOOT, IMEM_REQ=0; BOOT SHALL last exactly one cycle and then go to FETCH.
REQ-008 In FETCH, IMEM_REQ=1; on IMEM_VALID=1 with PCSRC=0, the PC SHALL advance to PC+4, with wrap-around modulo 2^WIDTH.
REQ-009 FETCH response routing: if the output register is empty or consumed this cycle, the response SHALL load the output register with INSTR_VALID=1 and the FSM SHALL stay in FETCH. Otherwise the response SHALL load the skid buffer and the FSM SHALL go to HOLD.
REQ-010 In HOLD, IMEM_REQ=0. When the output register is consumed, the skid buffer SHALL move to the output register (INSTR_VALID=1) and the FSM SHALL go to FETCH.
REQ-011 With zero-wait memory and STALL=0, throughput SHALL be one instruction per cycle, with one cycle of latency from IMEM_VALID to INSTR_VALID.
REQ-012 Redirect (PCSRC=1) SHALL take priority over STALL and IMEM_VALID in every state except BOOT. On the next edge:
- PC <= {BRANCH_TARGET[WIDTH-1:2], 2'b00}.
- INSTR_VALID <= 0.
- skid buffer discarded.
REQ-013 Redirect state transitions:
- Redirect in FETCH with no IMEM_VALID that cycle SHALL go to DRAIN.
- Redirect in FETCH with IMEM_VALID that cycle SHALL discard the response and stay in FETCH.
- Redirect in HOLD SHALL go to FETCH.
REQ-014 In DRAIN, IMEM_REQ=0; the first IMEM_VALID SHALL be discarded and the FSM SHALL go to FETCH. A further PCSRC in DRAIN SHALL update the PC and remain in DRAIN.
REQ-015 PCSRC asserted during BOOT SHALL be ignored.
REQ-016 No instruction SHALL be duplicated, skipped or reordered between redirects; the PC_OUT values of successive consumed instructions SHALL differ by exactly 4.

Reset
REQ-017 RST=1 SHALL immediately, independent of CLK, set:
- PC = RESET_PC, FSM = BOOT.
- IMEM_REQ = 0, INSTR_VALID = 0.
- INSTRUCTION = 32'h0000_0013 (NOP), PC_OUT = 0.
- skid buffer empty.
REQ-018 RST asserted mid-request SHALL abandon the request; any IMEM_VALID received during reset or during BOOT SHALL be ignored.

Verification
REQ-019 Reset release, RESET_PC=0, zero-wait memory returning the word address, STALL=0 -> IMEM_REQ rises 1 cycle after release; PC_OUT sequence 0,4,8,... with one INSTR_VALID per cycle.
REQ-020 STALL=1 for 3 cycles while INSTR_VALID=1 -> INSTRUCTION held; next response goes to skid, FSM=HOLD, IMEM_REQ=0; on STALL=0, PCs continue with no gap or duplicate.
REQ-021 3-cycle memory latency, PCSRC=1 with BRANCH_TARGET=32'h40 mid-wait -> INSTR_VALID=0, FSM=DRAIN; pending response dropped; next consumed PC_OUT=32'h40.
REQ-022 PCSRC=1 and IMEM_VALID=1 in the same cycle, BRANCH_TARGET=32'h103 -> response dropped; IMEM_ADDR=32'h100 next cycle.
REQ-023 PC=32'hFFFF_FFFC with a response returned -> next IMEM_ADDR=32'h0000_0000.
REQ-024 RST pulsed between clock edges while in HOLD -> outputs take their reset values immediately; FSM=BOOT; skid empty.
